surf4_spi_flash_seq: RTL

WISHBONE master that sequences the simple SPI core (SPCR/SPSR/SPDR/SPER at word offsets 0-3) and its slave-select line to run complete SPI flash commands without software byte-polling.
Accepts a command descriptor (opcode, optional 24-bit address, read length), streams the received data bytes out, and performs the one-time CCLK switchover dummy transfer with slave select deasserted.
Sits beside the SPI core in the ID/control block. Its WB master port is muxed onto the SPI core's slave port.

---
 rtl/surf4_spi_flash_seq.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/surf4_spi_flash_seq.sv
// WISHBONE master that drives the simple SPI core to run whole SPI flash commands
// (init, one-time dummy byte, opcode/address/data bytes). Optional write path: SURF4_SPI_SEQ_WRITE_EN.
module surf4_spi_flash_seq #(
  parameter logic [7:0] SPCR_INIT = 8'h50,
  parameter int         LEN_BITS  = 12,
  parameter int         POLL_MAX  = 1023
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [7:0]          cmd_opcode_i,
  input  logic                cmd_has_addr_i,
  input  logic [23:0]         cmd_addr_i,
  input  logic [LEN_BITS-1:0] cmd_len_i,
`ifdef SURF4_SPI_SEQ_WRITE_EN
  input  logic                cmd_write_i,
  input  logic [7:0]          wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
`endif
  output logic [7:0]          rd_data_o,
  output logic                rd_valid_o,
  output logic                busy_o,
  output logic                err_o,
  output logic                cs_o,
  output logic                spi_cyc_o,
  output logic                spi_stb_o,
  output logic                spi_we_o,
  output logic [1:0]          spi_adr_o,
  output logic [7:0]          spi_dat_o,
  input  logic [7:0]          spi_dat_i,
  input  logic                spi_ack_i
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  localparam logic [1:0] REG_SPCR = 2'd0;
  localparam logic [1:0] REG_SPSR = 2'd1;
  localparam logic [1:0] REG_SPDR = 2'd2;
  localparam logic [1:0] REG_SPER = 2'd3;

  typedef enum logic [3:0] {
    S_INIT_CR, S_INIT_ER, S_IDLE, S_SEL, S_WAITWR, S_TX, S_POLL, S_RX, S_RELEASE
  } state_t;

  typedef enum logic [1:0] {K_DUMMY, K_HDR, K_DATA} kind_t;

  state_t state, state_d;
  kind_t  kind;

  logic                gap;
  logic                init_done;
  logic                dummy_done;
  logic                err;
  logic                rd_valid;
  logic [7:0]          rd_data;
  logic [1:0]          hidx;
  logic [LEN_BITS-1:0] len_left;
  logic [PW-1:0]       poll_cnt;

  logic [7:0]  opcode;
  logic [23:0] addr;
  logic        has_addr;
  logic        write_cmd;
  logic [7:0]  wr_byte;

  logic       cyc, we;
  logic [1:0] adr;
  logic [7:0] dat;
  logic [7:0] tx_byte;
  logic       more_hdr, last_byte, next_data;
  logic       bus_ack, cmd_fire;

  assign cmd_ready_o = (state == S_IDLE) && init_done;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign bus_ack     = cyc && spi_ack_i;
  assign busy_o      = (state != S_IDLE);
  assign err_o       = err;
  assign rd_valid_o  = rd_valid;
  assign rd_data_o   = rd_data;
  assign spi_cyc_o   = cyc;
  assign spi_stb_o   = cyc;
  assign spi_we_o    = we;
  assign spi_adr_o   = adr;
  assign spi_dat_o   = dat;

  // Select is high from SEL through the last RX, except for the CCLK dummy byte.
  assign cs_o = ((state == S_SEL) || (state == S_WAITWR) || (state == S_TX) ||
                 (state == S_POLL) || (state == S_RX)) && (kind != K_DUMMY);

`ifdef SURF4_SPI_SEQ_WRITE_EN
  assign wr_ready_o = (state == S_WAITWR) && wr_valid_i;
`else
  assign write_cmd  = 1'b0;
  assign wr_byte    = 8'h00;
`endif

  always_comb begin
    tx_byte = 8'h00;
    case (kind)
      K_DUMMY: tx_byte = 8'hFF;
      K_HDR: begin
        case (hidx)
          2'd0:    tx_byte = opcode;
          2'd1:    tx_byte = addr[23:16];
          2'd2:    tx_byte = addr[15:8];
          default: tx_byte = addr[7:0];
        endcase
      end
      K_DATA:  tx_byte = write_cmd ? wr_byte : 8'h00;
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    more_hdr  = (kind == K_HDR) && has_addr && (hidx != 2'd3);
    next_data = (kind == K_DATA) || ((kind == K_HDR) && !more_hdr);
    last_byte = 1'b0;
    if (kind == K_HDR)
      last_byte = !more_hdr && (len_left == '0);
    else if (kind == K_DATA)
      last_byte = (len_left == LEN_BITS'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= S_INIT_CR;
    else
      state <= state_d;
  end

  // Bus ops hold cyc/stb until ack; gap forces the idle cycle after every ack.
  always_comb begin
    state_d = state;
    cyc     = 1'b0;
    we      = 1'b0;
    adr     = REG_SPCR;
    dat     = 8'h00;
    case (state)
      S_INIT_CR: begin
        cyc = !gap;
        we  = 1'b1;
        adr = REG_SPCR;
        dat = SPCR_INIT;
        if (bus_ack) state_d = S_INIT_ER;
      end
      S_INIT_ER: begin
        cyc = !gap;
        we  = 1'b1;
        adr = REG_SPER;
        dat = 8'h00;
        if (bus_ack) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_fire) state_d = dummy_done ? S_SEL : S_TX;
      end
      S_SEL: state_d = S_TX;
      S_WAITWR: begin
`ifdef SURF4_SPI_SEQ_WRITE_EN
        if (wr_valid_i) state_d = S_TX;
`else
        state_d = S_TX;
`endif
      end
      S_TX: begin
        cyc = !gap;
        we  = 1'b1;
        adr = REG_SPDR;
        dat = tx_byte;
        if (bus_ack) state_d = S_POLL;
      end
      S_POLL: begin
        cyc = !gap;
        adr = REG_SPSR;
        if (bus_ack) begin
          if (!spi_dat_i[0])
            state_d = S_RX;
          else if (poll_cnt == POLL_LAST)
            state_d = S_RELEASE;
        end
      end
      S_RX: begin
        cyc = !gap;
        adr = REG_SPDR;
        if (bus_ack) begin
          if (kind == K_DUMMY)
            state_d = S_SEL;
          else if (last_byte)
            state_d = S_RELEASE;
          else if (next_data && write_cmd)
            state_d = S_WAITWR;
          else
            state_d = S_TX;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_INIT_CR;
    endcase
    if (!cyc) begin
      we  = 1'b0;
      adr = REG_SPCR;
      dat = 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap        <= 1'b1;
      init_done  <= 1'b0;
      dummy_done <= 1'b0;
      err        <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
      kind       <= K_DUMMY;
      hidx       <= 2'd0;
      len_left   <= '0;
      poll_cnt   <= '0;
    end else begin
      gap      <= bus_ack;
      rd_valid <= 1'b0;
      case (state)
        S_INIT_ER: if (bus_ack) init_done <= 1'b1;
        S_IDLE: begin
          if (cmd_fire) begin
            err      <= 1'b0;
            hidx     <= 2'd0;
            len_left <= cmd_len_i;
            poll_cnt <= '0;
            kind     <= dummy_done ? K_HDR : K_DUMMY;
          end
        end
        S_TX: if (bus_ack) poll_cnt <= '0;
        S_POLL: begin
          if (bus_ack && spi_dat_i[0]) begin
            poll_cnt <= poll_cnt + PW'(1);
            if (poll_cnt == POLL_LAST) err <= 1'b1;
          end
        end
        S_RX: begin
          if (bus_ack) begin
            case (kind)
              K_DUMMY: begin
                dummy_done <= 1'b1;
                kind       <= K_HDR;
              end
              K_HDR: begin
                if (more_hdr) hidx <= hidx + 2'd1;
                else          kind <= K_DATA;
              end
              default: begin
                len_left <= len_left - LEN_BITS'(1);
                if (!write_cmd) begin
                  rd_valid <= 1'b1;
                  rd_data  <= spi_dat_i;
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Descriptor latch: only meaningful after a handshake, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (cmd_fire) begin
      opcode   <= cmd_opcode_i;
      addr     <= cmd_addr_i;
      has_addr <= cmd_has_addr_i;
`ifdef SURF4_SPI_SEQ_WRITE_EN
      write_cmd <= cmd_write_i;
`endif
    end
`ifdef SURF4_SPI_SEQ_WRITE_EN
    if ((state == S_WAITWR) && wr_valid_i)
      wr_byte <= wr_data_i;
`endif
  end

endmodule
